// File: rtl/idma_cmd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idma_cmd_arbiter_if                                             |
// | Brief    : AXI-Stream beat bundle (tdata/tvalid/tlast/tready) for iDMA arb |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface idma_cmd_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/idma_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idma_cmd_arbiter                                                |
// | Brief    : Shares one iDMA between RX (port 0) and TX (port 1) masters;    |
// |            packet arbitration plus in-order response routing via FIFO.     |
// |            Define IDMA_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module idma_cmd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  wire logic              aclk,
  input  wire logic              aresetn,
  idma_cmd_arbiter_if.slave      s0_cmd,
  idma_cmd_arbiter_if.slave      s1_cmd,
  idma_cmd_arbiter_if.master     m_cmd,
  idma_cmd_arbiter_if.slave      m_stat,
  idma_cmd_arbiter_if.master     s0_stat,
  idma_cmd_arbiter_if.master     s1_stat,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                   orphan_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_grant, w_grant_nxt;
  logic                  w_push, w_pop;
  logic [TAG_DEPTH-1:0]  r_fifo;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_orphan;
  logic                  w_full, w_empty, w_head;
  logic [DATA_WIDTH-1:0] w_cmd_data;
  logic                  w_cmd_valid, w_cmd_last;
  logic                  w_s0_ready, w_s1_ready, w_stat_ready;
`ifndef IDMA_ARB_FIXED_PRIO_EN
  logic                  r_rr_ptr, w_rr_nxt;
`endif

  assign w_full  = (r_count == CNT_W'(TAG_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifndef IDMA_ARB_FIXED_PRIO_EN
    w_rr_nxt    = r_rr_ptr;
`endif
    w_push      = 1'b0;
    w_cmd_data  = '0;
    w_cmd_valid = 1'b0;
    w_cmd_last  = 1'b0;
    w_s0_ready  = 1'b0;
    w_s1_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((s0_cmd.tvalid || s1_cmd.tvalid) && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = S_GRANT;
`ifdef IDMA_ARB_FIXED_PRIO_EN
          w_grant_nxt = !s0_cmd.tvalid;
`else
          w_grant_nxt = (s0_cmd.tvalid && s1_cmd.tvalid) ? r_rr_ptr : s1_cmd.tvalid;
`endif
        end
      end
      S_GRANT: begin
        if (r_grant) begin
          w_cmd_data  = s1_cmd.tdata;
          w_cmd_valid = s1_cmd.tvalid;
          w_cmd_last  = s1_cmd.tlast;
          w_s1_ready  = m_cmd.tready;
        end else begin
          w_cmd_data  = s0_cmd.tdata;
          w_cmd_valid = s0_cmd.tvalid;
          w_cmd_last  = s0_cmd.tlast;
          w_s0_ready  = m_cmd.tready;
        end
        // Grant is held across tvalid gaps; only the last beat releases it.
        if (w_cmd_valid && m_cmd.tready && w_cmd_last) begin
          w_state_nxt = S_IDLE;
`ifndef IDMA_ARB_FIXED_PRIO_EN
          w_rr_nxt    = ~r_grant;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign m_cmd.tdata   = w_cmd_data;
  assign m_cmd.tvalid  = w_cmd_valid;
  assign m_cmd.tlast   = w_cmd_last;
  assign s0_cmd.tready = w_s0_ready;
  assign s1_cmd.tready = w_s1_ready;

  // Responses follow the FIFO head; with nothing outstanding the beat is drained.
  always_comb begin
    w_stat_ready   = 1'b0;
    s0_stat.tdata  = '0;
    s0_stat.tvalid = 1'b0;
    s0_stat.tlast  = 1'b0;
    s1_stat.tdata  = '0;
    s1_stat.tvalid = 1'b0;
    s1_stat.tlast  = 1'b0;
    if (aresetn) begin
      if (w_empty) begin
        w_stat_ready = 1'b1;
      end else if (w_head) begin
        s1_stat.tdata  = m_stat.tdata;
        s1_stat.tvalid = m_stat.tvalid;
        s1_stat.tlast  = m_stat.tlast;
        w_stat_ready   = s1_stat.tready;
      end else begin
        s0_stat.tdata  = m_stat.tdata;
        s0_stat.tvalid = m_stat.tvalid;
        s0_stat.tlast  = m_stat.tlast;
        w_stat_ready   = s0_stat.tready;
      end
    end
  end

  assign m_stat.tready = w_stat_ready;
  assign w_pop         = !w_empty && m_stat.tvalid && w_stat_ready && m_stat.tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_grant_nxt;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_empty && m_stat.tvalid) begin
        r_orphan <= 1'b1;
      end
    end
  end

`ifndef IDMA_ARB_FIXED_PRIO_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rr_ptr <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_nxt;
    end
  end
`endif

  assign outstanding = r_count;
  assign orphan_err  = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_idma_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_idma_cmd_arbiter                                             |
// | Brief    : Directed self-checking bench for idma_cmd_arbiter               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_idma_cmd_arbiter;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   drv_done = 0;
  logic [2:0] outstanding;
  logic       orphan_err;
  logic [31:0] mon_data[$];
  int          mon_cyc[$];

  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) s0_cmd();
  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) s1_cmd();
  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) m_cmd();
  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) m_stat();
  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) s0_stat();
  idma_cmd_arbiter_if #(.DATA_WIDTH(32)) s1_stat();

  idma_cmd_arbiter #(.DATA_WIDTH(32), .TAG_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_cmd(s0_cmd), .s1_cmd(s1_cmd), .m_cmd(m_cmd),
    .m_stat(m_stat), .s0_stat(s0_stat), .s1_stat(s1_stat),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Log every command beat accepted by the iDMA together with its cycle.
  always @(negedge aclk) begin
    if (aresetn && m_cmd.tvalid && m_cmd.tready) begin
      mon_data.push_back(m_cmd.tdata);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic set_cmd(input int port, input logic v, input logic [31:0] d, input logic l);
    if (port == 0) begin s0_cmd.tvalid = v; s0_cmd.tdata = d; s0_cmd.tlast = l; end
    else           begin s1_cmd.tvalid = v; s1_cmd.tdata = d; s1_cmd.tlast = l; end
  endtask

  // Drives n 3-beat packets on a port; beat data = base + packet*16 + beat.
  task automatic drv(input int port, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 3; b++) begin
        int   budget;
        logic fire;
        budget = 0;
        fire   = 1'b0;
        set_cmd(port, 1'b1, 32'(base + k * 16 + b), (b == 2));
        while (!fire) begin
          @(negedge aclk);
          fire = (port == 0) ? (s0_cmd.tvalid && s0_cmd.tready) : (s1_cmd.tvalid && s1_cmd.tready);
          @(posedge aclk); #2;
          budget++;
          if (!fire && budget > 200) begin
            errors++; checks++;
            $display("FAIL drv_timeout port=%0d packet=%0d beat=%0d", port, k, b);
            set_cmd(port, 1'b0, 32'h0, 1'b0);
            return;
          end
        end
      end
    end
    set_cmd(port, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic send_resp(input logic [31:0] d);
    int   budget;
    logic fire;
    budget = 0;
    fire   = 1'b0;
    m_stat.tvalid = 1'b1; m_stat.tdata = d; m_stat.tlast = 1'b1;
    while (!fire && budget <= 50) begin
      @(negedge aclk);
      fire = m_stat.tvalid && m_stat.tready;
      @(posedge aclk); #2;
      budget++;
    end
    checks++;
    if (!fire) begin errors++; $display("FAIL resp_timeout data=%0h", d); end
    m_stat.tvalid = 1'b0; m_stat.tdata = '0; m_stat.tlast = 1'b0;
  endtask

  task automatic clear_inputs();
    set_cmd(0, 1'b0, 32'h0, 1'b0);
    set_cmd(1, 1'b0, 32'h0, 1'b0);
    m_cmd.tready = 1'b1;
    m_stat.tvalid = 1'b0; m_stat.tdata = '0; m_stat.tlast = 1'b0;
    s0_stat.tready = 1'b1; s1_stat.tready = 1'b1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk); #2;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    set_cmd(0, 1'b1, 32'h55, 1'b0);
    m_cmd.tready = 1'b1;
    m_stat.tvalid = 1'b1; m_stat.tdata = 32'h77; m_stat.tlast = 1'b1;
    s0_stat.tready = 1'b1; s1_stat.tready = 1'b1;
    repeat (2) @(posedge aclk); #3;
    checks++; if (m_stat.tready !== 1'b0) begin errors++; $display("FAIL rst_stat_ready got=%b exp=0", m_stat.tready); end
    checks++; if (s0_cmd.tready !== 1'b0) begin errors++; $display("FAIL rst_s0_cmd_ready got=%b exp=0", s0_cmd.tready); end
    checks++; if ({m_cmd.tvalid, m_cmd.tlast, m_cmd.tdata} !== 34'h0) begin errors++; $display("FAIL rst_m_cmd got=%b/%0h exp=0/0", m_cmd.tvalid, m_cmd.tdata); end
    checks++; if ({s0_stat.tvalid, s1_stat.tvalid, s0_stat.tdata} !== 34'h0) begin errors++; $display("FAIL rst_stat_out got=%b%b/%0h exp=00/0", s0_stat.tvalid, s1_stat.tvalid, s0_stat.tdata); end
    checks++; if (outstanding !== 3'd0 || orphan_err !== 1'b0) begin errors++; $display("FAIL rst_state got=%0d/%b exp=0/0", outstanding, orphan_err); end
    do_reset();
  endtask

  task automatic test_single_cmd();
    s0_cmd.tvalid = 1'b1; s0_cmd.tdata = 32'h100; s0_cmd.tlast = 1'b0;
    #1;
    checks++; if (s0_cmd.tready !== 1'b0 || m_cmd.tvalid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b%b exp=00", s0_cmd.tready, m_cmd.tvalid); end
    @(posedge aclk); #2;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outst1 got=%0d exp=1", outstanding); end
    checks++; if ({m_cmd.tvalid, s0_cmd.tready, m_cmd.tdata} !== {2'b11, 32'h100}) begin errors++; $display("FAIL single_c1 got=%b%b/%0h exp=11/100", m_cmd.tvalid, s0_cmd.tready, m_cmd.tdata); end
    @(posedge aclk); #2 s0_cmd.tdata = 32'h101; #1;
    checks++; if (m_cmd.tdata !== 32'h101) begin errors++; $display("FAIL single_c2 got=%0h exp=101", m_cmd.tdata); end
    @(posedge aclk); #2 s0_cmd.tdata = 32'h102; s0_cmd.tlast = 1'b1; #1;
    checks++; if ({m_cmd.tvalid, m_cmd.tlast, m_cmd.tdata} !== {2'b11, 32'h102}) begin errors++; $display("FAIL single_c3 got=%b%b/%0h exp=11/102", m_cmd.tvalid, m_cmd.tlast, m_cmd.tdata); end
    @(posedge aclk); #2 set_cmd(0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (m_cmd.tvalid !== 1'b0) begin errors++; $display("FAIL single_done got=%b exp=0", m_cmd.tvalid); end
    m_stat.tvalid = 1'b1; m_stat.tdata = 32'hDEAD; m_stat.tlast = 1'b1; #1;
    checks++; if ({s0_stat.tvalid, s1_stat.tvalid, s0_stat.tdata} !== {2'b10, 32'hDEAD}) begin errors++; $display("FAIL single_resp got=%b%b/%0h exp=10/dead", s0_stat.tvalid, s1_stat.tvalid, s0_stat.tdata); end
    @(posedge aclk); #2 m_stat.tvalid = 1'b0; m_stat.tlast = 1'b0; #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_outst0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_arbitration();
    do_reset();
    mon_data.delete(); mon_cyc.delete();
    fork
      drv(0, 2, 32'h000);
      drv(1, 2, 32'h100);
    join
    checks++; if (mon_data.size() != 12) begin errors++; $display("FAIL arb_beats got=%0d exp=12", mon_data.size()); end
    else begin
      for (int j = 0; j < 4; j++) begin
        int p, k;
`ifdef IDMA_ARB_FIXED_PRIO_EN
        p = j / 2; k = j % 2;
`else
        p = j % 2; k = j / 2;
`endif
        for (int b = 0; b < 3; b++) begin
          checks++;
          if (mon_data[j * 3 + b] !== 32'(p * 256 + k * 16 + b)) begin
            errors++; $display("FAIL arb_order pkt=%0d beat=%0d got=%0h exp=%0h", j, b, mon_data[j * 3 + b], p * 256 + k * 16 + b);
          end
        end
        if (j > 0) begin
          checks++;
          if (mon_cyc[j * 3] - mon_cyc[j * 3 - 3] != 4) begin errors++; $display("FAIL arb_gap pkt=%0d got=%0d exp=4", j, mon_cyc[j * 3] - mon_cyc[j * 3 - 3]); end
        end
      end
    end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL arb_outst got=%0d exp=4", outstanding); end
  endtask

  task automatic test_fifo_full();
    int budget;
    do_reset();
    mon_data.delete(); mon_cyc.delete();
    drv_done = 0;
    fork
      begin drv(0, 3, 32'h000); drv_done++; end
      begin drv(1, 3, 32'h100); drv_done++; end
    join_none
    repeat (40) @(posedge aclk); #3;
    checks++; if (mon_data.size() != 12 || outstanding !== 3'd4) begin errors++; $display("FAIL full_stop got=%0d beats/%0d outst exp=12/4", mon_data.size(), outstanding); end
    checks++; if (s0_cmd.tready !== 1'b0 || s1_cmd.tready !== 1'b0 || m_cmd.tvalid !== 1'b0) begin errors++; $display("FAIL full_block got=%b%b%b exp=000", s0_cmd.tready, s1_cmd.tready, m_cmd.tvalid); end
    @(posedge aclk); #2;
    send_resp(32'h1);
    budget = 0;
    while (mon_data.size() < 15 && budget < 20) begin @(posedge aclk); #2; budget++; end
    checks++; if (mon_data.size() != 15) begin errors++; $display("FAIL full_resume got=%0d exp=15", mon_data.size()); end
    send_resp(32'h2);
    budget = 0;
    while (drv_done < 2 && budget < 300) begin @(posedge aclk); #2; budget++; end
    checks++; if (drv_done != 2 || mon_data.size() != 18 || outstanding !== 3'd4) begin errors++; $display("FAIL full_final got=%0d/%0d/%0d exp=2/18/4", drv_done, mon_data.size(), outstanding); end
  endtask

  task automatic test_ordering();
    do_reset();
    drv(1, 1, 32'h100);
    drv(0, 1, 32'h000);
    drv(1, 1, 32'h110);
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL ord_outst3 got=%0d exp=3", outstanding); end
    s0_stat.tready = 1'b0; s1_stat.tready = 1'b1;
    m_stat.tvalid = 1'b1; m_stat.tdata = 32'hA; m_stat.tlast = 1'b1; #1;
    checks++; if ({s1_stat.tvalid, s0_stat.tvalid, m_stat.tready, s1_stat.tdata} !== {3'b101, 32'hA}) begin errors++; $display("FAIL ord_a got=%b%b%b/%0h exp=101/a", s1_stat.tvalid, s0_stat.tvalid, m_stat.tready, s1_stat.tdata); end
    @(posedge aclk); #2 m_stat.tdata = 32'hB; #1;
    checks++; if ({s1_stat.tvalid, s0_stat.tvalid, m_stat.tready, s0_stat.tdata} !== {3'b010, 32'hB}) begin errors++; $display("FAIL ord_b_stall got=%b%b%b/%0h exp=010/b", s1_stat.tvalid, s0_stat.tvalid, m_stat.tready, s0_stat.tdata); end
    @(posedge aclk); #3;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL ord_hold got=%0d exp=2", outstanding); end
    s0_stat.tready = 1'b1; #1;
    checks++; if (m_stat.tready !== 1'b1) begin errors++; $display("FAIL ord_b_go got=%b exp=1", m_stat.tready); end
    @(posedge aclk); #2 m_stat.tdata = 32'hC; #1;
    checks++; if ({s1_stat.tvalid, s0_stat.tvalid, s1_stat.tdata} !== {2'b10, 32'hC}) begin errors++; $display("FAIL ord_c got=%b%b/%0h exp=10/c", s1_stat.tvalid, s0_stat.tvalid, s1_stat.tdata); end
    @(posedge aclk); #2 m_stat.tvalid = 1'b0; m_stat.tlast = 1'b0; #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ord_outst0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_push_pop();
    int exp_q[$];
    do_reset();
    drv(0, 1, 32'h000);
    drv(1, 1, 32'h100);
    drv(0, 1, 32'h010);
    exp_q = '{0, 1, 0};
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL pp_fill got=%0d exp=3", outstanding); end
    for (int i = 0; i < 10; i++) begin
      int p, h;
      p = i % 2;
      h = exp_q[0];
      m_stat.tvalid = 1'b1; m_stat.tdata = 32'(32'h50 + i); m_stat.tlast = 1'b1;
      fork
        drv(p, 1, 32'(32'h200 + i * 16));
        begin
          @(negedge aclk);
          checks++;
          if ({s1_stat.tvalid, s0_stat.tvalid} !== ((h == 1) ? 2'b10 : 2'b01) ||
              ((h == 1) ? s1_stat.tdata : s0_stat.tdata) !== 32'(32'h50 + i)) begin
            errors++; $display("FAIL pp_route iter=%0d got=%b%b exp_port=%0d", i, s1_stat.tvalid, s0_stat.tvalid, h);
          end
          @(posedge aclk); #1;
          m_stat.tvalid = 1'b0; m_stat.tlast = 1'b0;
          checks++;
          if (outstanding !== 3'd3) begin errors++; $display("FAIL pp_count iter=%0d got=%0d exp=3", i, outstanding); end
        end
      join
      void'(exp_q.pop_front());
      exp_q.push_back(p);
    end
  endtask

  task automatic test_orphan_and_reset();
    do_reset();
    s0_stat.tready = 1'b0; s1_stat.tready = 1'b0;
    m_stat.tvalid = 1'b1; m_stat.tdata = 32'hBAD; m_stat.tlast = 1'b0; #1;
    checks++; if ({m_stat.tready, s0_stat.tvalid, s1_stat.tvalid} !== 3'b100) begin errors++; $display("FAIL orph_drain got=%b%b%b exp=100", m_stat.tready, s0_stat.tvalid, s1_stat.tvalid); end
    @(posedge aclk); #2 m_stat.tvalid = 1'b0; #1;
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orph_set got=%b exp=1", orphan_err); end
    @(posedge aclk); #2;
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orph_sticky got=%b exp=1", orphan_err); end
    s0_stat.tready = 1'b1; s1_stat.tready = 1'b1;
    s0_cmd.tvalid = 1'b1; s0_cmd.tdata = 32'h300; s0_cmd.tlast = 1'b0;
    @(posedge aclk); #2;
    @(posedge aclk); #2 s0_cmd.tdata = 32'h301; #1;
    checks++; if (m_cmd.tdata !== 32'h301 || outstanding !== 3'd1) begin errors++; $display("FAIL mid_c2 got=%0h/%0d exp=301/1", m_cmd.tdata, outstanding); end
    aresetn = 1'b0; #1;
    checks++; if ({m_cmd.tvalid, m_cmd.tlast, m_cmd.tdata} !== 34'h0 || s0_cmd.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd got=%b/%0h/%b exp=0/0/0", m_cmd.tvalid, m_cmd.tdata, s0_cmd.tready); end
    checks++; if (outstanding !== 3'd0 || orphan_err !== 1'b0 || m_stat.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_state got=%0d/%b/%b exp=0/0/0", outstanding, orphan_err, m_stat.tready); end
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_cmd();
    test_arbitration();
    test_fifo_full();
    test_ordering();
    test_push_pop();
    test_orphan_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
